// File: rtl/soundgen_pkg.sv
// rtl/soundgen_pkg.sv - shared constants, waveform encodings and LFSR step for the sound generator
package soundgen_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_ACC_W = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'b00,
        WAVE_SAW    = 2'b01,
        WAVE_TRI    = 2'b10,
        WAVE_NOISE  = 2'b11
    } wave_e;

    // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting right
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit maximal-length noise LFSR, seeded on reset, advanced on i_step
module lfsr16
    import soundgen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_step,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LFSR_SEED;
        end else if (i_step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - phase-accumulator tone source emitting one attenuated duty value per PWM frame
module tone_gen
    import soundgen_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] freq_word,
    input  logic [1:0]       wave_sel,
    input  logic [2:0]       atten,
    output logic [N-1:0]     sample_out,
    output logic             sample_valid,
    output logic             frame_start
);

    localparam logic [N-1:0] MIDSCALE = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0]     r_fcnt;
    logic [ACC_W-1:0] r_phase;
    logic [N-1:0]     r_sample;
    logic             r_valid;

    logic             w_tick;
    logic             w_step;
    logic [15:0]      w_lfsr;
    logic [ACC_W-1:0] w_phase_nxt;
    logic [N-1:0]     w_p;
    logic [N-1:0]     w_tri;
    logic [N-1:0]     w_raw;
    logic [N-1:0]     w_shaped;

    assign w_tick = (r_fcnt == {N{1'b1}});
    assign w_step = w_tick & en;

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_step  (w_step),
        .o_state (w_lfsr)
    );

    // The sample is formed from the values being captured at the tick edge,
    // so configuration inputs only matter on the last cycle of a frame.
    assign w_phase_nxt = r_phase + freq_word;
    assign w_p         = w_phase_nxt[ACC_W-1 -: N];
    assign w_tri       = {w_p[N-2:0], 1'b0};

    always_comb begin
        w_raw = '0;
        case (wave_e'(wave_sel))
            WAVE_SQUARE: w_raw = w_p[N-1] ? '0 : '1;
            WAVE_SAW:    w_raw = w_p;
            WAVE_TRI:    w_raw = w_p[N-1] ? ~w_tri : w_tri;
            WAVE_NOISE:  w_raw = N'(lfsr_next(w_lfsr));
        endcase
    end

    assign w_shaped = w_raw >> atten;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt   <= '0;
            r_phase  <= '0;
            r_sample <= MIDSCALE;
            r_valid  <= 1'b0;
        end else begin
            r_fcnt  <= r_fcnt + N'(1);
            r_valid <= w_tick;
            if (w_step) begin
                r_phase <= w_phase_nxt;
            end
            if (w_tick) begin
                r_sample <= en ? w_shaped : MIDSCALE;
            end
        end
    end

    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign frame_start  = (r_fcnt == '0);

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - table-driven scoreboard bench for tone_gen
module tb_tone_gen;

    localparam int N     = 8;
    localparam int ACC_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [ACC_W-1:0] freq_word = '0;
    logic [1:0]       wave_sel = 2'b00;
    logic [2:0]       atten = 3'd0;
    logic [N-1:0]     sample_out;
    logic             sample_valid;
    logic             frame_start;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rst;
        bit          en;
        logic [1:0]  wave;
        logic [15:0] freq;
        logic [2:0]  atten;
        logic [7:0]  exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_sample = 8'h80;
    logic       last_valid = 1'b0;

    always #5 clk = ~clk;

    tone_gen #(.N(N), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .freq_word    (freq_word),
        .wave_sel     (wave_sel),
        .atten        (atten),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .frame_start  (frame_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit r, input bit e, input logic [1:0] w, input logic [15:0] f,
                           input logic [2:0] a, input logic [7:0] x);
        vec_t v;
        v.rst = r; v.en = e; v.wave = w; v.freq = f; v.atten = a; v.exp = x;
        vecs.push_back(v);
    endtask

    // Scoreboard: pop on every valid pulse, otherwise the output must hold
    always @(negedge clk) begin
        if (!rst_n) begin
            last_sample = 8'h80;
            last_valid  = 1'b0;
        end else begin
            if (sample_valid) begin
                check("valid_width", {31'b0, last_valid}, 32'd0);
                check("frame_start_at_valid", {31'b0, frame_start}, 32'd1);
                check("valid_expected", exp_q.size() > 0 ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) begin
                    check("sample", {24'b0, sample_out}, {24'b0, exp_q.pop_front()});
                end
            end else begin
                check("hold", {24'b0, sample_out}, {24'b0, last_sample});
            end
            last_sample = sample_out;
            last_valid  = sample_valid;
        end
    end

    task automatic wait_sample(input string name, input int lat);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, lat);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_sample", {24'b0, sample_out}, 32'h80);
        check("rst_valid", {31'b0, sample_valid}, 32'd0);
        check("rst_frame_start", {31'b0, frame_start}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // saw ramp
        add_vec(1, 1, 2'b01, 16'h0100, 3'd0, 8'h01);
        add_vec(0, 1, 2'b01, 16'h0100, 3'd0, 8'h02);
        add_vec(0, 1, 2'b01, 16'h0100, 3'd0, 8'h03);
        // zero increment is constant
        add_vec(1, 1, 2'b01, 16'h0000, 3'd0, 8'h00);
        add_vec(0, 1, 2'b01, 16'h0000, 3'd0, 8'h00);
        // square, period 4 frames, phase wraps through zero
        add_vec(1, 1, 2'b00, 16'h4000, 3'd0, 8'hFF);
        add_vec(0, 1, 2'b00, 16'h4000, 3'd0, 8'h00);
        add_vec(0, 1, 2'b00, 16'h4000, 3'd0, 8'h00);
        add_vec(0, 1, 2'b00, 16'h4000, 3'd0, 8'hFF);
        add_vec(0, 1, 2'b00, 16'h4000, 3'd0, 8'hFF);
        add_vec(0, 1, 2'b00, 16'h4000, 3'd0, 8'h00);
        // triangle
        add_vec(1, 1, 2'b10, 16'h2000, 3'd0, 8'h40);
        add_vec(0, 1, 2'b10, 16'h2000, 3'd0, 8'h80);
        add_vec(0, 1, 2'b10, 16'h2000, 3'd0, 8'hC0);
        add_vec(0, 1, 2'b10, 16'h2000, 3'd0, 8'hFF);
        add_vec(0, 1, 2'b10, 16'h2000, 3'd0, 8'hBF);
        add_vec(0, 1, 2'b10, 16'h2000, 3'd0, 8'h7F);
        // noise, gated for 3 frames (wave change with en low), then resumes
        add_vec(1, 1, 2'b11, 16'h1234, 3'd0, 8'h70);
        add_vec(0, 1, 2'b11, 16'h1234, 3'd0, 8'h38);
        add_vec(0, 0, 2'b00, 16'h1234, 3'd0, 8'h80);
        add_vec(0, 0, 2'b11, 16'h1234, 3'd0, 8'h80);
        add_vec(0, 0, 2'b11, 16'h1234, 3'd0, 8'h80);
        add_vec(0, 1, 2'b11, 16'h1234, 3'd0, 8'h9C);
        // attenuated saw
        add_vec(1, 1, 2'b01, 16'h0F00, 3'd3, 8'h01);
        add_vec(0, 1, 2'b01, 16'h0F00, 3'd3, 8'h03);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            en        = vecs[i].en;
            wave_sel  = vecs[i].wave;
            freq_word = vecs[i].freq;
            atten     = vecs[i].atten;
            exp_q.push_back(vecs[i].exp);
            wait_sample($sformatf("vec%0d", i), 256);
        end

        // mid-frame atten change only affects the sample after the next tick
        repeat (50) begin
            @(negedge clk);
            #1;
        end
        atten = 3'd0;
        repeat (20) begin
            @(negedge clk);
            #1;
        end
        check("atten_midframe_hold", {24'b0, sample_out}, 32'h03);
        exp_q.push_back(8'h2D);
        wait_sample("atten_change", 186);

        // async reset in the middle of a frame
        freq_word = 16'h0100;
        repeat (100) begin
            @(negedge clk);
            #1;
        end
        check("mid_frame_start", {31'b0, frame_start}, 32'd0);
        check("mid_sample", {24'b0, sample_out}, 32'h2D);
        rst_n = 1'b0;
        #1;
        check("async_rst_sample", {24'b0, sample_out}, 32'h80);
        check("async_rst_valid", {31'b0, sample_valid}, 32'd0);
        check("async_rst_frame_start", {31'b0, frame_start}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(8'h01);
        wait_sample("after_reset", 256);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Upstream sample source for the PWM DAC stage in the sound generator.
- Runs a phase-accumulator oscillator that produces square, sawtooth, triangle or noise waveforms, with coarse attenuation.
- Emits one N-bit duty value per PWM frame (2^N clocks), so the DAC's t_on input stays stable for a full PWM period and changes only at a frame boundary.

Parameters:
- N, 8, sample width in bits; also sets frame length to 2^N clocks (matches the DAC bitwidth).
- ACC_W, 16, phase accumulator width in bits; must satisfy ACC_W >= N+1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  oscillator enable; low gives silence (midscale).
- freq_word  in  ACC_W  phase increment per frame.
- wave_sel  in  2  waveform select: 00 square, 01 saw, 10 triangle, 11 noise.
- atten  in  3  attenuation as a right shift of 0..7.
- sample_out  out  N  duty value for the DAC t_on input.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- frame_start  out  1  high when the frame counter is 0.

Behaviour:
- Clock and reset: single clock domain on clk; rst_n is asynchronous and active-low.
- Reset values:
  - fcnt = 0, phase = 0, lfsr = 16'hACE1, shadow config registers = 0.
  - sample_out = 2^(N-1), i.e. 128 at defaults.
  - sample_valid = 0; frame_start = 1, since fcnt is 0.
  - Reset asserted mid-operation returns every register to these values immediately, with no completion of the frame in progress.
- Frame counter: fcnt is N bits, increments every cycle and wraps from 2^N-1 to 0. tick = (fcnt == 2^N-1).
- On tick with en=1:
  - phase <= (phase + freq_word) mod 2^ACC_W.
  - lfsr advances one Fibonacci step: shift right, new bit15 = l[0]^l[2]^l[3]^l[5] (x^16+x^14+x^13+x^11+1).
  - freq_word, wave_sel and atten are captured into shadow registers. Input changes mid-frame have no effect until the next tick.
- On tick with en=0:
  - phase and lfsr hold.
  - The next sample is midscale 2^(N-1).
- Sample register, at fcnt==0 (one cycle after tick), using the post-tick phase and shadow registers:
  - p = phase[ACC_W-1 -: N].
  - square: p[N-1]==0 gives all ones, else 0.
  - saw: p.
  - triangle: t = {p[N-2:0],1'b0}; output t when p[N-1]==0, else ~t.
  - noise: lfsr[N-1:0].
  - result = raw >> atten (unsigned, zero fill).
  - sample_out loads the result and sample_valid pulses for exactly 1 cycle. sample_out is otherwise held for the whole frame.
- Latency: tick to new sample_out is 1 cycle. The first sample_valid after reset is at cycle 2^N (256), counting the first cycle after reset release as cycle 0.
- Boundary cases:
  - freq_word=0 gives a constant waveform output.
  - Phase wraps modulo 2^ACC_W silently.
  - wave_sel changing together with en falling: en wins (midscale).
  - lfsr never reaches 0 and has period 65535 ticks.

Decomposition:
- Shared package soundgen_pkg holds:
  - wave_sel encodings WAVE_SQUARE/SAW/TRI/NOISE;
  - LFSR_SEED = 16'hACE1;
  - the default N.
- One natural sub-module, lfsr16: step enable input, 16-bit state output, seed loaded on reset.
- Waveform shaping stays inline in tone_gen.

Test Plan:
1. saw, en=1, atten=0, freq_word=0x0100 -> sample_valid at cycles 256, 512, 768; sample_out = 1, 2, 3; sample_out constant between pulses.
2. square, freq_word=0x4000 -> successive samples 255, 0, 0, 255, repeating with period 4 frames.
3. triangle, freq_word=0x2000 -> successive samples 0x40, 0x80, 0xC0, 0xFF, 0xBF, 0x7F.
4. saw, atten=3, freq_word=0x0F00 -> first sample p=0x0F gives 0x01; second sample p=0x1E gives 0x03. Changing atten mid-frame alters only the sample after the next tick.
5. noise, freq_word arbitrary -> first sample 0x70 (lfsr 0x5670). Toggle en=0 for 3 frames -> outputs 128 and lfsr holds; on re-enable the sequence resumes at the next LFSR state.
6. Assert rst_n=0 at fcnt=100 mid-saw -> sample_out=128, sample_valid=0, frame_start=1 asynchronously. After release, the first sample_valid is again at cycle 256.
